// File: rtl/hv_efuse_loader_if.sv
// Efuse-load handshake, efuse macro bus and register-file write port.
// The loader is the slave side; the control FSM, efuse macro and register file form the master side.
interface hv_efuse_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              i_efuse_load_req;
    logic              o_efuse_load_done;
    logic              o_reg_efuse_vld;
    logic              o_efuse_busy;
    logic              o_efuse_csb;
    logic              o_efuse_strobe;
    logic [ADDR_W-1:0] o_efuse_addr;
    logic [DATA_W-1:0] i_efuse_rdata;
    logic              o_reg_wr_en;
    logic [ADDR_W-1:0] o_reg_addr;
    logic [DATA_W-1:0] o_reg_wdata;

    modport slave (
        input  i_efuse_load_req, i_efuse_rdata,
        output o_efuse_load_done, o_reg_efuse_vld, o_efuse_busy, o_efuse_csb,
               o_efuse_strobe, o_efuse_addr, o_reg_wr_en, o_reg_addr, o_reg_wdata
    );

    modport master (
        output i_efuse_load_req, i_efuse_rdata,
        input  o_efuse_load_done, o_reg_efuse_vld, o_efuse_busy, o_efuse_csb,
               o_efuse_strobe, o_efuse_addr, o_reg_wr_en, o_reg_addr, o_reg_wdata
    );
endinterface

// File: rtl/hv_efuse_loader.sv
// Serial efuse reader: copies EFUSE_WORD_NUM-1 words into the HV register file,
// checks the trailing XOR checksum word and reports done/valid to the control FSM.
module hv_efuse_loader #(
    parameter int                      EFUSE_WORD_NUM = 8,
    parameter int                      EFUSE_DATA_W   = 8,
    parameter int                      EFUSE_ADDR_W   = 3,
    parameter int                      SETUP_CYC      = 2,
    parameter int                      STROBE_CYC     = 4,
    parameter logic [EFUSE_DATA_W-1:0] CHK_SEED       = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    hv_efuse_loader_if.slave  efuse_if
);

    localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, CHECK, DONE, REL} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cyc_cnt;
    logic [EFUSE_ADDR_W-1:0] idx;
    logic [EFUSE_DATA_W-1:0] acc;
    logic [EFUSE_DATA_W-1:0] chk_word;
    logic                    load_done, efuse_vld, busy, csb, strobe, wr_en;
    logic [EFUSE_ADDR_W-1:0] reg_addr;
    logic [EFUSE_DATA_W-1:0] reg_wdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Dropping the request anywhere inside the read sequence abandons the load.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (efuse_if.i_efuse_load_req) state_nxt = SETUP;
            SETUP:   if (!efuse_if.i_efuse_load_req)                 state_nxt = IDLE;
                     else if (cyc_cnt == CNT_W'(SETUP_CYC - 1))      state_nxt = STROBE;
            STROBE:  if (!efuse_if.i_efuse_load_req)                 state_nxt = IDLE;
                     else if (cyc_cnt == CNT_W'(STROBE_CYC - 1))     state_nxt = CAPTURE;
            CAPTURE: if (!efuse_if.i_efuse_load_req)                 state_nxt = IDLE;
                     else if (idx == LAST_IDX)                       state_nxt = CHECK;
                     else                                            state_nxt = SETUP;
            CHECK:   if (!efuse_if.i_efuse_load_req)                 state_nxt = IDLE;
                     else                                            state_nxt = DONE;
            DONE:    state_nxt = REL;
            REL:     if (!efuse_if.i_efuse_load_req)                 state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cyc_cnt   <= '0;
            idx       <= '0;
            acc       <= '0;
            chk_word  <= '0;
            load_done <= 1'b0;
            efuse_vld <= 1'b0;
            busy      <= 1'b0;
            csb       <= 1'b1;
            strobe    <= 1'b0;
            wr_en     <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            cyc_cnt   <= (state_nxt == state && (state == SETUP || state == STROBE))
                         ? cyc_cnt + 1'b1 : '0;
            csb       <= !(state_nxt inside {SETUP, STROBE, CAPTURE});
            strobe    <= (state_nxt == STROBE);
            busy      <= (state_nxt inside {SETUP, STROBE, CAPTURE, CHECK, DONE});
            load_done <= (state_nxt == DONE);
            wr_en     <= 1'b0;

            if (state == IDLE && state_nxt == SETUP) begin
                efuse_vld <= 1'b0;
                idx       <= '0;
                acc       <= CHK_SEED;
            end
            if (state == CAPTURE && state_nxt == SETUP) begin
                wr_en     <= 1'b1;
                reg_addr  <= idx;
                reg_wdata <= efuse_if.i_efuse_rdata;
                acc       <= acc ^ efuse_if.i_efuse_rdata;
                idx       <= idx + 1'b1;
            end
            if (state == CAPTURE && state_nxt == CHECK)
                chk_word <= efuse_if.i_efuse_rdata;
            if (state == CHECK && state_nxt == DONE)
                efuse_vld <= (acc == chk_word);
        end
    end

    assign efuse_if.o_efuse_load_done = load_done;
    assign efuse_if.o_reg_efuse_vld   = efuse_vld;
    assign efuse_if.o_efuse_busy      = busy;
    assign efuse_if.o_efuse_csb       = csb;
    assign efuse_if.o_efuse_strobe    = strobe;
    assign efuse_if.o_efuse_addr      = idx;
    assign efuse_if.o_reg_wr_en       = wr_en;
    assign efuse_if.o_reg_addr        = reg_addr;
    assign efuse_if.o_reg_wdata       = reg_wdata;

endmodule

// File: tb/tb_hv_efuse_loader.sv
// Directed bench for hv_efuse_loader: a table of efuse images with expected checksum results,
// plus hand-written abort, held-request and mid-load reset sequences.
module tb_hv_efuse_loader;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    hv_efuse_loader_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    hv_efuse_loader dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .efuse_if (bus)
    );

    logic [7:0] mem [8];
    assign bus.i_efuse_rdata = mem[bus.o_efuse_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus monitor: logs writes and counts protocol events/violations for the test to inspect.
    int         wr_total = 0, done_total = 0, str_total = 0;
    int         bad_stb_w = 0, bad_setup = 0, bad_addr = 0, bad_csb = 0;
    int         stb_run = 0, setup_run = 0;
    logic [2:0] wlog_a [256];
    logic [7:0] wlog_d [256];
    logic       p_stb = 1'b0, p_csb = 1'b1;
    logic [2:0] p_addr = 3'd0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            stb_run   <= 0;
            setup_run <= 0;
            p_stb     <= 1'b0;
            p_csb     <= 1'b1;
            p_addr    <= 3'd0;
        end else begin
            if (bus.o_reg_wr_en) begin
                wlog_a[wr_total % 256] <= bus.o_reg_addr;
                wlog_d[wr_total % 256] <= bus.o_reg_wdata;
                wr_total <= wr_total + 1;
            end
            if (bus.o_efuse_load_done) done_total <= done_total + 1;
            if (bus.o_efuse_strobe && !p_stb) begin
                str_total <= str_total + 1;
                if (setup_run != 2) bad_setup <= bad_setup + 1;
            end
            if (bus.o_efuse_strobe && bus.o_efuse_csb) bad_csb <= bad_csb + 1;
            if (bus.o_efuse_strobe) stb_run <= p_stb ? stb_run + 1 : 1;
            if (!bus.o_efuse_strobe && p_stb && !bus.o_efuse_csb && stb_run != 4)
                bad_stb_w <= bad_stb_w + 1;
            if ((bus.o_efuse_strobe || (p_stb && !bus.o_efuse_csb)) && bus.o_efuse_addr != p_addr)
                bad_addr <= bad_addr + 1;
            if (!bus.o_efuse_csb && !bus.o_efuse_strobe) begin
                if (p_csb || bus.o_efuse_addr != p_addr) setup_run <= 1;
                else if (!p_stb)                         setup_run <= setup_run + 1;
                else                                     setup_run <= 0;
            end
            p_stb  <= bus.o_efuse_strobe;
            p_csb  <= bus.o_efuse_csb;
            p_addr <= bus.o_efuse_addr;
        end
    end

    typedef struct {
        logic [7:0][7:0] words;
        logic            exp_vld;
        int              hold;
    } vec_t;

    // One full load; done is expected 57 edges after the request edge k0,
    // i.e. in the cycle that closes at edge k0+58.
    task automatic run_load(input logic [7:0][7:0] words, input logic exp_vld, input int hold);
        int  e, w0, d0, s0, b0;
        bit  seen;
        for (int i = 0; i < 8; i++) mem[i] = words[i];
        w0 = wr_total; d0 = done_total;
        b0 = bad_stb_w + bad_setup + bad_addr + bad_csb;
        @(negedge i_clk);
        bus.i_efuse_load_req = 1'b1;
        e = -1; seen = 1'b0;
        while (!seen && e < 200) begin
            @(posedge i_clk); e++; #1;
            if (e == 0) chk("vld_clr_at_start", bus.o_reg_efuse_vld, 1'b0);
            if (bus.o_efuse_load_done) seen = 1'b1;
        end
        chk("done_seen", seen, 1'b1);
        chk("done_latency", e, 57);
        chk("vld_at_done", bus.o_reg_efuse_vld, exp_vld);
        s0 = str_total;
        repeat (hold) @(posedge i_clk);
        #1 chk("busy_in_rel", bus.o_efuse_busy, 1'b0);
        @(negedge i_clk);
        bus.i_efuse_load_req = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("no_strobe_after_done", str_total - s0, 0);
        chk("one_done", done_total - d0, 1);
        chk("vld_sticky", bus.o_reg_efuse_vld, exp_vld);
        chk("csb_idle", bus.o_efuse_csb, 1'b1);
        chk("timing_violations", bad_stb_w + bad_setup + bad_addr + bad_csb - b0, 0);
        chk("write_count", wr_total - w0, 7);
        for (int i = 0; i < 7; i++) begin
            chk("wr_addr", wlog_a[(w0 + i) % 256], i);
            chk("wr_data", wlog_d[(w0 + i) % 256], words[i]);
        end
    endtask

    vec_t vecs [6];
    logic [7:0][7:0] nominal;

    initial begin
        int w0, d0, n;
        bit hit;

        vecs[0] = '{words: {8'hA5, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, exp_vld: 1'b1, hold: 10};
        vecs[1] = '{words: {8{8'h00}},                                                exp_vld: 1'b0, hold: 1};
        vecs[2] = '{words: {8'hA4, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, exp_vld: 1'b0, hold: 1};
        vecs[3] = '{words: {8'h5A, {7{8'hFF}}},                                      exp_vld: 1'b1, hold: 1};
        vecs[4] = '{words: {8'hA5, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10}, exp_vld: 1'b1, hold: 1};
        vecs[5] = '{words: {8'hA5, {7{8'h00}}},                                      exp_vld: 1'b1, hold: 1};
        nominal = vecs[0].words;

        bus.i_efuse_load_req = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_csb", bus.o_efuse_csb, 1'b1);
        chk("rst_strobe", bus.o_efuse_strobe, 1'b0);
        chk("rst_busy", bus.o_efuse_busy, 1'b0);
        chk("rst_done", bus.o_efuse_load_done, 1'b0);
        chk("rst_vld", bus.o_reg_efuse_vld, 1'b0);
        chk("rst_addr", bus.o_efuse_addr, 3'd0);
        chk("rst_wr_en", bus.o_reg_wr_en, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Table-driven loads; vector 0 also holds the request 10 cycles past done.
        for (int v = 0; v < 6; v++) run_load(vecs[v].words, vecs[v].exp_vld, vecs[v].hold);

        // Abort during word 3 strobe.
        for (int i = 0; i < 8; i++) mem[i] = nominal[i];
        w0 = wr_total; d0 = done_total;
        @(negedge i_clk);
        bus.i_efuse_load_req = 1'b1;
        hit = 1'b0; n = 0;
        while (!hit && n < 200) begin
            @(negedge i_clk); n++;
            if (bus.o_efuse_addr == 3'd3 && bus.o_efuse_strobe) hit = 1'b1;
        end
        chk("abort_reach_word3", hit, 1'b1);
        bus.i_efuse_load_req = 1'b0;
        @(posedge i_clk);
        #1;
        chk("abort_csb", bus.o_efuse_csb, 1'b1);
        chk("abort_strobe", bus.o_efuse_strobe, 1'b0);
        chk("abort_busy", bus.o_efuse_busy, 1'b0);
        repeat (5) @(posedge i_clk);
        #1;
        chk("abort_no_done", done_total - d0, 0);
        chk("abort_vld", bus.o_reg_efuse_vld, 1'b0);
        chk("abort_writes", wr_total - w0, 3);
        run_load(nominal, 1'b1, 1);

        // Asynchronous reset during word 5 setup.
        w0 = wr_total;
        @(negedge i_clk);
        bus.i_efuse_load_req = 1'b1;
        hit = 1'b0; n = 0;
        while (!hit && n < 200) begin
            @(negedge i_clk); n++;
            if (bus.o_efuse_addr == 3'd5 && !bus.o_efuse_csb && !bus.o_efuse_strobe) hit = 1'b1;
        end
        chk("rst_reach_word5", hit, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_csb", bus.o_efuse_csb, 1'b1);
        chk("arst_strobe", bus.o_efuse_strobe, 1'b0);
        chk("arst_busy", bus.o_efuse_busy, 1'b0);
        chk("arst_vld", bus.o_reg_efuse_vld, 1'b0);
        chk("arst_addr", bus.o_efuse_addr, 3'd0);
        chk("arst_writes", wr_total - w0, 5);
        bus.i_efuse_load_req = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("post_rst_idle_csb", bus.o_efuse_csb, 1'b1);
        chk("post_rst_idle_busy", bus.o_efuse_busy, 1'b0);
        run_load(nominal, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hv_efuse_loader.md
Name: hv_efuse_loader

Overview:
- Responder side of the HV efuse-load handshake. Accepts the load request from the HV control FSM and reads EFUSE_WORD_NUM words serially from the efuse macro.
- Writes each data word into the HV register file and checks a trailing checksum word.
- Returns a one-cycle load-done pulse together with the efuse-valid flag that the control FSM uses to pick WAIT→NML or WAIT→TEST.

Parameters:
- EFUSE_WORD_NUM, 8, total words read including the checksum word (last address); minimum 2.
- EFUSE_DATA_W, 8, efuse word width.
- EFUSE_ADDR_W, 3, efuse/register address width; must satisfy 2**EFUSE_ADDR_W >= EFUSE_WORD_NUM.
- SETUP_CYC, 2, cycles that address and csb are held before the strobe; minimum 1.
- STROBE_CYC, 4, strobe-high width in cycles; minimum 1.
- CHK_SEED, 8'hA5, checksum seed, so that an unprogrammed all-zero efuse fails.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_efuse_load_req  in  1  level request from the HV control FSM.
- o_efuse_load_done  out  1  one-cycle completion pulse.
- o_reg_efuse_vld  out  1  checksum-pass flag; sticky until the next load starts.
- o_efuse_busy  out  1  high from SETUP entry through the DONE cycle.
- o_efuse_csb  out  1  efuse macro chip select, active low.
- o_efuse_strobe  out  1  efuse read strobe.
- o_efuse_addr  out  EFUSE_ADDR_W  efuse word address.
- i_efuse_rdata  in  EFUSE_DATA_W  efuse read data, stable while the strobe is low after a read.
- o_reg_wr_en  out  1  register-file write pulse.
- o_reg_addr  out  EFUSE_ADDR_W  register-file write address.
- o_reg_wdata  out  EFUSE_DATA_W  register-file write data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs are registered. o_efuse_csb=1; every other output = 0. FSM state = IDLE.
- FSM states: IDLE, SETUP, STROBE, CAPTURE, CHECK, DONE, REL.
- IDLE: i_efuse_load_req sampled 1 → go to SETUP. On the same edge, clear o_reg_efuse_vld, clear word counter and checksum accumulator (accumulator loads CHK_SEED). o_efuse_csb goes 0; o_efuse_addr = 0.
- SETUP: hold for SETUP_CYC cycles, then go to STROBE.
- STROBE: o_efuse_strobe=1 for STROBE_CYC cycles, then go to CAPTURE with the strobe low.
- CAPTURE: one cycle; register i_efuse_rdata.
  - If word index < EFUSE_WORD_NUM-1: on the next cycle o_reg_wr_en=1 for exactly one cycle, with o_reg_addr = index and o_reg_wdata = captured data. Accumulator ^= data. Index increments, o_efuse_addr follows, go to SETUP.
  - If word index = EFUSE_WORD_NUM-1 (checksum word): no register write; go to CHECK.
- CHECK: one cycle. pass = (accumulator == checksum word). o_efuse_csb returns to 1.
- DONE: one cycle. o_efuse_load_done=1 and o_reg_efuse_vld=pass, both valid in this same cycle. Then go to REL.
- REL: wait until i_efuse_load_req=0, then go to IDLE. This prevents a re-trigger, because the requester drops the request one cycle after done.
- Latency: request first sampled at edge k0 → done high in cycle k0 + 2 + EFUSE_WORD_NUM*(SETUP_CYC+STROBE_CYC+1). With defaults this is k0+58.
- Abort: i_efuse_load_req=0 in any of SETUP, STROBE, CAPTURE or CHECK → next state IDLE. On abort: csb=1, strobe=0, no done pulse, o_reg_efuse_vld stays 0. A write pulse already scheduled from CAPTURE still completes.
- Request held high in REL: the block stays in REL indefinitely with no second load.
- Address/counter: the index never exceeds EFUSE_WORD_NUM-1; no wrap-around.
- Asynchronous reset mid-load returns the block to reset values immediately. Partially written registers are the register file's responsibility.
- o_efuse_strobe is never 1 while o_efuse_csb=1.

Test Plan:
- Nominal load: efuse words 0..6 = 8'h01..8'h07, word7 = 8'hA5^8'h01^…^8'h07 = 8'hA5. Expect 7 write pulses with addr 0..6 and data 8'h01..8'h07, done at k0+58, o_reg_efuse_vld=1.
- Unprogrammed efuse, all words 0: 7 writes of 0, done at k0+58, o_reg_efuse_vld=0 (8'hA5 ≠ 0).
- Abort: drop the request during word 3 STROBE. Expect csb=1 next cycle, no done, vld=0, exactly 3 write pulses. Re-assert the request → a full fresh load with done at the new k0+58.
- Held request: keep the request high for 10 cycles after done. Expect exactly one done pulse and no further strobes. Drop the request, re-raise it → a second load runs and vld is cleared at its start.
- Reset: assert i_rst in the middle of word 5 SETUP. Expect csb=1, strobe=0, busy=0, vld=0 asynchronously (before the next clock edge), and state IDLE.
- Timing check across the whole load (SETUP_CYC=2, STROBE_CYC=4): strobe pulses are exactly 4 cycles wide, preceded by 2 setup cycles each; address stays stable from SETUP entry until CAPTURE ends.
